// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART TX scheduler.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } sched_state_e;

  localparam logic GNT_REQ0 = 1'b0;
  localparam logic GNT_REQ1 = 1'b1;

  // Minimum watchdog counter width; widened automatically for larger limits.
  localparam int unsigned WDOG_W_DEF = 8;

endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-input round-robin arbiter: combinational winner/ready, registered pointer.
module rr_arb2
  import uart_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic       en,
  input  logic       upd,
  input  logic       upd_owner,
  output logic       gnt_c,
  output logic [1:0] ready_c
);

  logic ptr_q;

  // After a transfer the pointer favours the requester that did not own it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= GNT_REQ0;
    end else if (upd) begin
      ptr_q <= ~upd_owner;
    end
  end

  always_comb begin
    gnt_c   = ptr_q;
    ready_c = 2'b00;
    if (req_valid == 2'b01) begin
      gnt_c = GNT_REQ0;
    end else if (req_valid == 2'b10) begin
      gnt_c = GNT_REQ1;
    end
    if (en && req_valid[gnt_c]) begin
      ready_c = (gnt_c == GNT_REQ1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// TX byte-channel scheduler: round-robin between two requesters, low byte first.
// Optional watchdog abort enabled by defining UART_TX_SCHED_WDOG_EN.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ0_VALID,
  input  logic [2*DATA_WIDTH-1:0] REQ0_DATA,
  input  logic                    REQ0_LEN,
  output logic                    REQ0_READY,
  input  logic                    REQ1_VALID,
  input  logic [DATA_WIDTH-1:0]   REQ1_DATA,
  output logic                    REQ1_READY,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_DATA_VALID,
  input  logic                    TX_BUSY,
  output logic                    SCHED_BUSY,
  output logic                    GRANT,
  output logic                    SCHED_ERR
);

  localparam int unsigned HOLD_W = 2 * DATA_WIDTH;

  sched_state_e          state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  len_q, len_d;
  logic                  idx_q, idx_d;
  logic                  grant_q, grant_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  arb_en_c;
  logic                  arb_upd_c;
  logic                  arb_gnt_c;
  logic [1:0]            arb_ready_c;

`ifdef UART_TX_SCHED_WDOG_EN
  localparam int unsigned WDOG_W =
    (32'($clog2(WDOG_CYCLES)) > WDOG_W_DEF) ? 32'($clog2(WDOG_CYCLES)) : WDOG_W_DEF;
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
`endif

  assign arb_en_c = (state_q == IDLE) && !TX_BUSY;

  rr_arb2 u_arb (
    .clk       (CLK),
    .rst       (RST),
    .req_valid ({REQ1_VALID, REQ0_VALID}),
    .en        (arb_en_c),
    .upd       (arb_upd_c),
    .upd_owner (grant_q),
    .gnt_c     (arb_gnt_c),
    .ready_c   (arb_ready_c)
  );

  assign REQ0_READY    = arb_ready_c[0];
  assign REQ1_READY    = arb_ready_c[1];
  assign TX_DATA       = tx_data_q;
  assign TX_DATA_VALID = valid_q;
  assign SCHED_BUSY    = busy_q;
  assign GRANT         = grant_q;

`ifdef UART_TX_SCHED_WDOG_EN
  assign SCHED_ERR = err_q;
`else
  assign SCHED_ERR = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      len_q     <= 1'b0;
      idx_q     <= 1'b0;
      grant_q   <= GNT_REQ0;
      tx_data_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef UART_TX_SCHED_WDOG_EN
      wdog_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
`ifdef UART_TX_SCHED_WDOG_EN
      wdog_cnt_q <= wdog_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    len_d     = len_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    err_d     = 1'b0;
    arb_upd_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|arb_ready_c) begin
          hold_d  = (arb_gnt_c == GNT_REQ1) ? HOLD_W'(REQ1_DATA) : REQ0_DATA;
          len_d   = (arb_gnt_c == GNT_REQ1) ? 1'b0 : REQ0_LEN;
          grant_d = arb_gnt_c;
          idx_d   = 1'b0;
          state_d = SEND;
        end
      end
      SEND: state_d = WAIT_HI;
      WAIT_HI: begin
        if (TX_BUSY) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!TX_BUSY) begin
          if (idx_q < len_q) begin
            idx_d   = 1'b1;
            state_d = SEND;
          end else begin
            state_d   = IDLE;
            arb_upd_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef UART_TX_SCHED_WDOG_EN
    // Stuck transmitter handshake: drop the rest of the transfer.
    if (((state_q == WAIT_HI) || (state_q == WAIT_LO)) &&
        (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1))) begin
      state_d   = IDLE;
      arb_upd_c = 1'b1;
      err_d     = 1'b1;
    end
    wdog_cnt_d = '0;
    if ((state_d == state_q) && ((state_q == WAIT_HI) || (state_q == WAIT_LO))) begin
      wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
    end
`endif

    if (state_d == SEND) begin
      tx_data_d = idx_d ? hold_d[DATA_WIDTH +: DATA_WIDTH] : hold_d[DATA_WIDTH-1:0];
    end
    valid_d = (state_d == SEND);
    busy_d  = (state_d != IDLE);
  end

endmodule
